// File: rtl/led_breathe_pwm_if.sv
// Control/observation bundle for the LED breathing stage: run controls in, LED drives and ramp status out.
interface led_breathe_pwm_if #(
    parameter int PWM_BITS = 8
);
    logic                en;
    logic [1:0]          mode;
    logic                led_1;
    logic                led_2;
    logic                led_3;
    logic                led_4;
    logic [1:0]          state;
    logic [PWM_BITS-1:0] duty;

    modport master (
        output en, mode,
        input  led_1, led_2, led_3, led_4, state, duty
    );

    modport slave (
        input  en, mode,
        output led_1, led_2, led_3, led_4, state, duty
    );
endinterface

// File: rtl/led_breathe_pwm.sv
// Four-LED PWM breathing driver: prescaled ramp FSM (up/hold/down/hold) feeding per-LED duty compares.
// Optional macro LED_GAMMA_EN squares each per-LED duty ((d*d)>>PWM_BITS) for perceptually linear fading.
module led_breathe_pwm #(
    parameter int PWM_BITS   = 8,
    parameter int STEP_DIV   = 40000,
    parameter int HOLD_STEPS = 32
) (
    input  logic             clk_in,
    input  logic             rst_n,
    led_breathe_pwm_if.slave bus
);
    localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
    localparam int                  HOLD_W    = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [23:0]         STEP_LAST = 24'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    localparam logic [1:0] MODE_BREATHE   = 2'd0;
    localparam logic [1:0] MODE_ALTERNATE = 2'd1;
    localparam logic [1:0] MODE_FULL      = 2'd2;
    localparam logic [1:0] MODE_OFF       = 2'd3;

    typedef enum logic [1:0] {
        UP      = 2'd0,
        HOLD_HI = 2'd1,
        DOWN    = 2'd2,
        HOLD_LO = 2'd3
    } ramp_state_t;

    ramp_state_t         state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [23:0]         step_cnt;
    logic                step_tick;
    logic [3:0]          led_q;

    assign step_tick = bus.en && (step_cnt == STEP_LAST);

    // PWM counter and step prescaler both freeze while en is low.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt  <= '0;
            step_cnt <= '0;
        end else if (bus.en) begin
            pwm_cnt  <= pwm_cnt + 1'b1;
            step_cnt <= step_tick ? 24'd0 : step_cnt + 24'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UP;
            duty_q     <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        hold_cnt_d = hold_cnt_q;
        if (step_tick) begin
            case (state_q)
                UP: begin
                    if (duty_q == MAX) begin
                        state_d    = HOLD_HI;
                        hold_cnt_d = '0;
                    end else begin
                        duty_d = duty_q + 1'b1;
                    end
                end
                HOLD_HI: begin
                    if (hold_cnt_q == HOLD_LAST) state_d = DOWN;
                    else                         hold_cnt_d = hold_cnt_q + 1'b1;
                end
                DOWN: begin
                    if (duty_q == '0) begin
                        state_d    = HOLD_LO;
                        hold_cnt_d = '0;
                    end else begin
                        duty_d = duty_q - 1'b1;
                    end
                end
                HOLD_LO: begin
                    if (hold_cnt_q == HOLD_LAST) state_d = UP;
                    else                         hold_cnt_d = hold_cnt_q + 1'b1;
                end
                default: state_d = UP;
            endcase
        end
    end

    // d_a drives LEDs 1/3, d_b drives LEDs 2/4 (complemented in ALTERNATE).
    logic [PWM_BITS-1:0] d_a, d_b, eff_a, eff_b;
    assign d_a = duty_q;
    assign d_b = (bus.mode == MODE_ALTERNATE) ? (MAX - duty_q) : duty_q;

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq_a, sq_b;
    assign sq_a  = {{PWM_BITS{1'b0}}, d_a} * {{PWM_BITS{1'b0}}, d_a};
    assign sq_b  = {{PWM_BITS{1'b0}}, d_b} * {{PWM_BITS{1'b0}}, d_b};
    assign eff_a = PWM_BITS'(sq_a >> PWM_BITS);
    assign eff_b = PWM_BITS'(sq_b >> PWM_BITS);
`else
    assign eff_a = d_a;
    assign eff_b = d_b;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else if (!bus.en) begin
            led_q <= '0;
        end else begin
            case (bus.mode)
                MODE_FULL:    led_q <= 4'b1111;
                MODE_OFF:     led_q <= 4'b0000;
                MODE_BREATHE,
                MODE_ALTERNATE: led_q <= {pwm_cnt < eff_b, pwm_cnt < eff_a,
                                          pwm_cnt < eff_b, pwm_cnt < eff_a};
                default:      led_q <= 4'b0000;
            endcase
        end
    end

    assign bus.led_1 = led_q[0];
    assign bus.led_2 = led_q[1];
    assign bus.led_3 = led_q[2];
    assign bus.led_4 = led_q[3];
    assign bus.state = state_q;
    assign bus.duty  = duty_q;
endmodule

// File: tb/tb_led_breathe_pwm.sv
// Directed bench for led_breathe_pwm: a ramp-phase arithmetic model checked every cycle plus literal pins.
module tb_led_breathe_pwm;
    localparam int PW     = 4;
    localparam int SDIV   = 4;
    localparam int HOLD   = 2;
    localparam int MAXV   = (1 << PW) - 1;
    localparam int PERIOD = 2 * (MAXV + 1 + HOLD);

    logic clk_in = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    led_breathe_pwm_if #(.PWM_BITS(PW)) bus ();

    led_breathe_pwm #(
        .PWM_BITS  (PW),
        .STEP_DIV  (SDIV),
        .HOLD_STEPS(HOLD)
    ) dut (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    // Ramp position as a pure function of enabled clocks since reset.
    function automatic int phase_of(input int nn);
        return (nn / SDIV) % PERIOD;
    endfunction

    function automatic int duty_of(input int nn);
        int p;
        p = phase_of(nn);
        if (p <= MAXV)            return p;
        if (p <= MAXV + HOLD)     return MAXV;
        if (p <= 2*MAXV + HOLD + 1) return MAXV - (p - (MAXV + HOLD + 1));
        return 0;
    endfunction

    function automatic int state_of(input int nn);
        int p;
        p = phase_of(nn);
        if (p <= MAXV)            return 0;
        if (p <= MAXV + HOLD)     return 1;
        if (p <= 2*MAXV + HOLD + 1) return 2;
        return 3;
    endfunction

    function automatic int shape(input int d);
`ifdef LED_GAMMA_EN
        return (d * d) / (MAXV + 1);
`else
        return d;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: enabled-clock count n plus the LED vector expected after each edge.
    int         n = 0;
    logic [3:0] exp_leds = 4'b0000;

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            n        = 0;
            exp_leds = 4'b0000;
        end else if (!bus.en) begin
            exp_leds = 4'b0000;
        end else begin
            int d, da, db, pwm;
            d   = duty_of(n);
            pwm = n % (MAXV + 1);
            da  = shape(d);
            db  = shape((bus.mode == 2'd1) ? (MAXV - d) : d);
            case (bus.mode)
                2'd2:    exp_leds = 4'b1111;
                2'd3:    exp_leds = 4'b0000;
                default: exp_leds = {pwm < db, pwm < da, pwm < db, pwm < da};
            endcase
            n = n + 1;
        end
    end

    always @(negedge clk_in) begin
        check("leds_model", {bus.led_4, bus.led_3, bus.led_2, bus.led_1}, exp_leds);
        check("duty_model", bus.duty, duty_of(n));
        check("state_model", bus.state, state_of(n));
    end

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk_in);
        #1;
    endtask

    int c1, c2, c3, c4;
    int e15;
    logic [PW-1:0] frozen_duty;
    logic [1:0]    frozen_state;

    typedef struct { logic en; logic [1:0] mode; int cycles; } vec_t;
    vec_t tbl[7];

    initial begin
        e15 = shape(MAXV);
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.mode = 2'd0;
        step(2);
        check("reset_leds", {bus.led_4, bus.led_3, bus.led_2, bus.led_1}, 4'b0000);
        check("reset_state", bus.state, 2'd0);
        check("reset_duty", bus.duty, 4'd0);

        rst_n = 1'b1;
        bus.en = 1'b1;
        step(4);
        check("ramp_first_step", bus.duty, 4'd1);
        step(56);
        check("ramp_top_duty", bus.duty, 4'd15);
        check("ramp_top_state", bus.state, 2'd0);

        // Duty stays 15 across edges 61..76: one full PWM period.
        c1 = 0; c2 = 0; c3 = 0; c4 = 0;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            c1 += bus.led_1; c2 += bus.led_2; c3 += bus.led_3; c4 += bus.led_4;
            if (i == 4)  check("hold_hi_at_64", bus.state, 2'd1);
            if (i == 12) check("down_at_72", bus.state, 2'd2);
        end
        check("down_first_dec", bus.duty, 4'd14);
        check("breathe15_led1", c1, e15);
        check("breathe15_led2", c2, e15);
        check("breathe15_led3", c3, e15);
        check("breathe15_led4", c4, e15);

        step(56);
        check("down_bottom_duty", bus.duty, 4'd0);
        check("down_bottom_state", bus.state, 2'd2);

        // ALTERNATE across the duty-0 window (edges 133..148).
        bus.mode = 2'd1;
        c1 = 0; c2 = 0; c3 = 0; c4 = 0;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            c1 += bus.led_1; c2 += bus.led_2; c3 += bus.led_3; c4 += bus.led_4;
            if (i == 4) check("hold_lo_at_136", bus.state, 2'd3);
            if (i == 12) begin
                check("up_at_144", bus.state, 2'd0);
                check("up_at_144_duty", bus.duty, 4'd0);
            end
        end
        check("alt0_led1", c1, 0);
        check("alt0_led2", c2, e15);
        check("alt0_led3", c3, 0);
        check("alt0_led4", c4, e15);

        bus.mode = 2'd2;
        step(1);
        check("mode_full", {bus.led_4, bus.led_3, bus.led_2, bus.led_1}, 4'b1111);
        bus.mode = 2'd3;
        step(1);
        check("mode_off", {bus.led_4, bus.led_3, bus.led_2, bus.led_1}, 4'b0000);
        bus.mode = 2'd0;
        check("phase_kept_duty", bus.duty, 4'd1);

        frozen_duty  = bus.duty;
        frozen_state = bus.state;
        bus.en = 1'b0;
        step(1);
        check("en0_leds", {bus.led_4, bus.led_3, bus.led_2, bus.led_1}, 4'b0000);
        step(99);
        check("en0_duty_frozen", bus.duty, frozen_duty);
        check("en0_state_frozen", bus.state, frozen_state);
        bus.en = 1'b1;
        step(2);
        check("en1_resume_duty", bus.duty, 4'd2);

        step(72);
        check("pre_reset_state", bus.state, 2'd2);
        check("pre_reset_duty", bus.duty, 4'd13);
        rst_n = 1'b0;
        #1;
        check("async_reset_leds", {bus.led_4, bus.led_3, bus.led_2, bus.led_1}, 4'b0000);
        check("async_reset_state", bus.state, 2'd0);
        check("async_reset_duty", bus.duty, 4'd0);
        rst_n = 1'b1;
        step(4);
        check("restart_duty", bus.duty, 4'd1);

        tbl[0] = '{1'b1, 2'd1, 40};
        tbl[1] = '{1'b1, 2'd0, 25};
        tbl[2] = '{1'b0, 2'd2, 7};
        tbl[3] = '{1'b1, 2'd2, 5};
        tbl[4] = '{1'b1, 2'd3, 9};
        tbl[5] = '{1'b1, 2'd1, 60};
        tbl[6] = '{1'b1, 2'd0, 200};
        foreach (tbl[i]) begin
            bus.en   = tbl[i].en;
            bus.mode = tbl[i].mode;
            step(tbl[i].cycles);
        end

        step(1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_breathe_pwm.md
Name: led_breathe_pwm

Overview:
- Downstream LED drive stage for the board's four user LEDs.
- Replaces the plain on/off blink with per-LED PWM brightness.
- A step prescaler and a four-state ramp FSM sweep a duty value up, hold, down, hold, continuously.
- A mode input selects how the duty maps onto led_1..led_4 (breathe, alternate, full, off).

Parameters:
- PWM_BITS, 8, duty/PWM counter width; MAX = 2^PWM_BITS-1
- STEP_DIV, 40000, clk_in cycles per duty step (≥2; prescaler is 24 bits)
- HOLD_STEPS, 32, steps spent in each hold state (≥1)

Ports:
- clk_in  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  run enable; 0 freezes all counters/FSM and forces LEDs off
- mode  input  2  0=BREATHE, 1=ALTERNATE, 2=FULL, 3=OFF
- led_1  output  1  LED drive, registered
- led_2  output  1  LED drive, registered
- led_3  output  1  LED drive, registered
- led_4  output  1  LED drive, registered
- state  output  2  FSM state: 0=UP, 1=HOLD_HI, 2=DOWN, 3=HOLD_LO
- duty  output  PWM_BITS  current ramp duty

Behaviour:
- Reset: one clock domain (clk_in); rst_n is asynchronous, active-low. While rst_n=0:
  - pwm_cnt, step_cnt, hold_cnt and duty are 0; state=UP; led_1..4 are 0.
  - Asserting rst_n mid-operation forces all of the above immediately, without waiting for a clock edge.
- pwm_cnt: increments every clk_in while en=1; wraps MAX→0.
- step_cnt: counts 0..STEP_DIV-1 while en=1; wraps to 0. step_tick is a one-cycle internal pulse when step_cnt==STEP_DIV-1.
- FSM (evaluated only on step_tick):
  - UP: if duty==MAX then go to HOLD_HI and set hold_cnt=0; else duty+1.
  - HOLD_HI: if hold_cnt==HOLD_STEPS-1 then go to DOWN; else hold_cnt+1.
  - DOWN: if duty==0 then go to HOLD_LO and set hold_cnt=0; else duty-1.
  - HOLD_LO: if hold_cnt==HOLD_STEPS-1 then go to UP; else hold_cnt+1.
  - duty never wraps.
  - UP and DOWN each take MAX+1 ticks; each hold takes HOLD_STEPS ticks.
  - Full period = 2*(MAX+1+HOLD_STEPS)*STEP_DIV clocks.
- Per-LED duty d_k by mode:
  - BREATHE: d_k = duty for all k.
  - ALTERNATE: d_1 = d_3 = duty; d_2 = d_4 = MAX-duty.
  - FULL / OFF: the compare result is overridden (see below).
- LED register, updated each clk_in:
  - en=0: led_k <= 0.
  - en=1, mode FULL: led_k <= 1.
  - en=1, mode OFF: led_k <= 0.
  - otherwise: led_k <= (pwm_cnt < d_k).
  - Duty 0 gives always off; MAX gives on MAX of every MAX+1 cycles.
  - Latency: one clock from pwm_cnt/duty/mode to led_k.
- Mode change: takes effect on the next clock edge. The FSM and counters run independently of mode, so the ramp phase is preserved across changes.
- en deassert: all counters, state and duty hold their values. On re-assert, counting resumes from the held values, with no restart.
- Simultaneous step_tick and pwm wrap: independent; both apply in the same cycle.

Optional Feature:
- Macro: LED_GAMMA_EN.
- Defined: each d_k in BREATHE/ALTERNATE is replaced by (d_k*d_k)>>PWM_BITS, computed combinationally, for perceptually linear fading. LED latency is unchanged; the duty port still shows the linear ramp value.
- Undefined: linear mapping exactly as above; no multiplier is inferred.

Test Plan:
- Bench parameters: PWM_BITS=4, STEP_DIV=4, HOLD_STEPS=2 (MAX=15).
- Reset: pulse rst_n=0 between clock edges during DOWN -> led_1..4=0, state=0, duty=0 immediately, before the next edge; ramp restarts from duty 0 after release.
- Ramp, mode=0, en=1: duty goes 0→15 in +1 steps every 4 clocks; state becomes 1 at tick 16 (clock 64), 2 at tick 18, 3 at tick 34, 0 at tick 36 (clock 144, period repeats).
- PWM: with duty held at 5 (en toggled to freeze), mode=0 -> each led_k high exactly 5 of every 16 clocks once en=1; duty=0 -> never high.
- ALTERNATE: mode=1 at duty=3 -> led_1/led_3 high 3/16 cycles; led_2/led_4 high 12/16 cycles.
- Overrides:
  - mode=2 -> all LEDs 1 from the next clock.
  - mode=3 -> all LEDs 0.
  - en=0 -> LEDs 0, duty/state frozen for 100 clocks; on en=1, duty resumes from the same value.
- LED_GAMMA_EN defined, mode=0:
  - duty=8 -> high 4/16 clocks.
  - duty=15 -> high 14/16 clocks.
  - duty=3 -> high 0/16 clocks.
